// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the decoder's branch/jump controls and the fetch state machine.
package cpu_ctrl_pkg;

    localparam logic [1:0] BRJ_SEQ    = 2'b00;
    localparam logic [1:0] BRJ_JUMP   = 2'b01;
    localparam logic [1:0] BRJ_BRANCH = 2'b10;

    localparam logic [1:0] PCT_OFFSET = 2'b00;
    localparam logic [1:0] PCT_REG    = 2'b01;
    localparam logic [1:0] PCT_INDEX  = 2'b10;

    localparam logic [2:0] CMP_EQ  = 3'b000;
    localparam logic [2:0] CMP_NE  = 3'b101;
    localparam logic [2:0] CMP_LEZ = 3'b010;
    localparam logic [2:0] CMP_GTZ = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluation on register operands; unknown compop encodings are not taken.
module branch_cmp
    import cpu_ctrl_pkg::*;
(
    input  logic [2:0]  compop,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        taken
);

    always_comb begin
        taken = 1'b0;
        case (compop)
            CMP_EQ:  taken = (rs_val == rt_val);
            CMP_NE:  taken = (rs_val != rt_val);
            CMP_LEZ: taken = ($signed(rs_val) <= 32'sd0);
            CMP_GTZ: taken = ($signed(rs_val) > 32'sd0);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch with one instruction in flight.
// Optional BRANCH_DELAY_SLOT_EN defers taken redirects by one (delay-slot) instruction.
//
// state | meaning
// IDLE  | after reset, about to issue the first fetch
// FETCH | imem_req asserted at imem_addr, waiting for imem_ack
// HOLD  | instr valid, waiting for the datapath to consume it
module pc_fetch_unit
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [1:0]  selbrjumpz,
    input  logic [1:0]  selpctype,
    input  logic [2:0]  compop,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        redirect
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  p4;
    logic [31:0]  branch_off;
    logic [31:0]  target_raw;
    logic [31:0]  target;
    logic [31:0]  next_pc;
    logic         redirect_next;
    logic         taken;

`ifdef BRANCH_DELAY_SLOT_EN
    logic         pending;
    logic [31:0]  pending_target;
    logic         set_pending;
`endif

    branch_cmp u_branch_cmp (
        .compop (compop),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .taken  (taken)
    );

    always_comb begin
        p4         = pc + 32'd4;
        branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
        target_raw = p4;
        case (selbrjumpz)
            BRJ_JUMP: begin
                case (selpctype)
                    PCT_REG:   target_raw = rs_val;
                    PCT_INDEX: target_raw = {p4[31:28], instr[25:0], 2'b00};
                    default:   target_raw = p4;
                endcase
            end
            BRJ_BRANCH: begin
                if (taken) begin
                    target_raw = p4 + branch_off;
                end
            end
            default: target_raw = p4;
        endcase
        target = {target_raw[31:2], 2'b00};
    end

`ifdef BRANCH_DELAY_SLOT_EN
    // While a redirect is pending, the consumed instruction is the delay slot and its own controls are ignored.
    always_comb begin
        set_pending   = 1'b0;
        next_pc       = p4;
        redirect_next = 1'b0;
        if (pending) begin
            next_pc       = pending_target;
            redirect_next = 1'b1;
        end else begin
            set_pending = (target != p4);
        end
    end
`else
    always_comb begin
        next_pc       = target;
        redirect_next = (target != p4);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            redirect    <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
            pending        <= 1'b0;
            pending_target <= '0;
`endif
        end else begin
            redirect <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state     <= ST_FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_data;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        pc          <= next_pc;
                        imem_addr   <= next_pc;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                        redirect    <= redirect_next;
                        state       <= ST_FETCH;
`ifdef BRANCH_DELAY_SLOT_EN
                        pending <= set_pending;
                        if (set_pending) begin
                            pending_target <= target;
                        end
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
